core_fetch: RTL and testbench
=============================

// Module: core_fetch
// PURPOSE
//  Fetch stage directly upstream of core_decode.
//  - Generates the PC and issues word fetches to instruction memory over a request/grant port with in-order responses.
//  - Predecodes returned words for a static branch prediction.
//  - Buffers {pc, ir, predicted_taken} and presents them to decode through a valid/ready handshake.
//  - Decode/execute flushes and redirects arrive on a redirect port.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset
//  DEPTH     2              fetch-buffer entries (power of 2, >=2); also caps requests in flight
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   reset, synchronous, active-high
//  imem_req            out  1   fetch request valid
//  imem_addr           out  32  fetch address, bits[1:0]=0
//  imem_gnt            in   1   request accepted this cycle (imem_req & imem_gnt)
//  imem_rvalid         in   1   response valid; in order, >=1 cycle after accept
//  imem_rdata          in   32  instruction word
//  redirect            in   1   flush fetch and restart at redirect_pc
//  redirect_pc         in   32  restart address; bits[1:0] ignored and forced to 0
//  d_valid             out  1   instruction available to decode
//  d_ready             in   1   decode accepts (transfer = d_valid & d_ready)
//  d_pc                out  32  PC of presented instruction
//  d_ir                out  32  presented instruction word
//  d_predicted_taken   out  1   static prediction for presented instruction
// BEHAVIOUR
//  Reset state:
//  - pc=RESET_PC; buffer empty; inflight=0; drop=0.
//  - Outputs: d_valid=0, imem_req=0, d_pc=0, d_ir=0, d_predicted_taken=0.
//  Request rule:
//  - imem_req = ~rst & ~redirect & (inflight + count < DEPTH).
//  - imem_addr = pc.
//  - Because of this credit, a response never finds the buffer full.
//  Accept: pc <= pc+4 (32-bit wrap), request PC pushed to the tag queue, inflight+1.
//  Response (imem_rvalid, inflight>0):
//  - Pop the tag queue; inflight-1.
//  - If drop>0: drop-1 and discard the word.
//  - Otherwise predecode:
//    - opcode 1100011 with ir[31]=1 -> taken, target = tag+B-imm.
//    - opcode 1101111 (JAL) -> taken, target = tag+J-imm.
//    - else predicted_taken=0. JALR is never predicted.
//  - Push {tag, ir, pt} into the buffer.
//  - If pt=1: pc <= target; drop <= inflight after this cycle, counting any request accepted in the same cycle.
//  - Stray imem_rvalid with inflight=0 is ignored.
//  Output: d_* is driven from the buffer head, zero-latency. The head is popped on transfer.
//  - Latency: response at cycle N -> d_valid=1 at N+1.
//  - With a 1-cycle memory: 1 instruction/cycle sustained.
//  Redirect (cycle N):
//  - Buffer cleared; pc <= {redirect_pc[31:2],2'b00}.
//  - drop <= inflight after cycle N; a response in cycle N is discarded.
//  - d_valid=0 at N+1; a first request to redirect_pc can be issued at N+1.
//  - Priority: redirect > predicted redirect > sequential PC+4.
//  - Any decode transfer in cycle N still completes.
//  Simultaneous push and pop in one cycle:
//  - count unchanged; FIFO order preserved.
//  - If the buffer is empty, the pushed entry is presented the next cycle (no bypass).
//  rst mid-operation: all state returns to reset values next cycle. imem is reset by the same rst.
// STRUCTURE
//  Package rv: OP_BRANCH, OP_JAL opcode constants; fetch_entry_t struct {pc, ir, predicted_taken}.
//  Sub-module core_fetch_fifo:
//  - Parameters: WIDTH and DEPTH. Synchronous FIFO with push, pop, clear, count, empty and full.
//  - Instanced twice: the fetch buffer (fetch_entry_t) and the PC tag queue (32 bits).
//  Counters inflight and drop are $clog2(DEPTH)+1 bits wide.
// TESTING
//  1. Reset release, 1-cycle memory, NOPs, d_ready=1:
//     - imem_addr 0x0,0x4,0x8,...
//     - First d_valid on the 3rd cycle after reset; one d_pc per cycle, incrementing by 4.
//  2. d_ready=0 for 5 cycles:
//     - Buffer fills to DEPTH and imem_req drops to 0.
//     - On release, PCs resume in order with no loss or duplication.
//  3. Word 0xFE000EE3 (beq x0,x0,-4) at PC 0x10:
//     - d_predicted_taken=1 for it; next delivered PC 0x0C.
//     - The in-flight fetch of 0x14 is dropped.
//  4. redirect=1, redirect_pc=0x103 while 2 requests are in flight:
//     - Both responses are discarded; d_valid=0 next cycle.
//     - Next imem_addr is 0x100.
//  5. redirect in the same cycle as a predicted-taken response:
//     - Redirect wins; the response is discarded.
//     - Next fetch is from redirect_pc.
//  6. Random grant/rvalid delays with random d_ready:
//     - The scoreboard sees d_pc sequence == architectural PC sequence.
//     - imem_req is never high while inflight+count==DEPTH.

Source files
------------

// File: rtl/core_fetch_pkg.sv
// Shared definitions for the fetch stage: opcode constants, the fetch-buffer
// entry layout and the static-prediction predecode helpers.
package rv;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // One instruction as handed to decode.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic        predicted_taken;
   } fetch_entry_t;

   // Predecode outcome: sequential, backward conditional branch, or JAL.
   typedef enum logic [1:0] {
      PD_SEQ    = 2'd0,
      PD_BRANCH = 2'd1,
      PD_JAL    = 2'd2
   } pd_kind_t;

   // Backward branches (sign bit set) are predicted taken, JAL always;
   // JALR is never predicted because its target needs a register value.
   function automatic pd_kind_t predecode(input logic [31:0] ir);
      pd_kind_t kind;
      kind = PD_SEQ;
      if (ir[6:0] == OP_BRANCH && ir[31]) begin
         kind = PD_BRANCH;
      end else if (ir[6:0] == OP_JAL) begin
         kind = PD_JAL;
      end
      return kind;
   endfunction

   // Sign-extended B-type immediate.
   function automatic logic [31:0] imm_b(input logic [31:0] ir);
      return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
   endfunction

   // Sign-extended J-type immediate.
   function automatic logic [31:0] imm_j(input logic [31:0] ir);
      return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Small synchronous FIFO with clear. The head word is visible combinationally
// so the consumer sees an entry the cycle after it was pushed, never earlier.
module core_fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    pop,
   input  logic                    clear,
   output logic [WIDTH-1:0]        rdata,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty,
   output logic                    full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   // Next pointer/occupancy; clear wins over any push or pop in that cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because occupancy gates their use.
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/core_fetch.sv
// Fetch stage: PC generation, in-order instruction-memory requests, static
// branch predecode and a small buffer presented to decode via valid/ready.
module core_fetch
   import rv::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        d_valid,
   input  logic        d_ready,
   output logic [31:0] d_pc,
   output logic [31:0] d_ir,
   output logic        d_predicted_taken
);

   localparam int             CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]    CREDITS = (CW+1)'(DEPTH);
   localparam int             EW      = $bits(fetch_entry_t);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] inflight, inflight_next;
   logic [CW-1:0] buf_count;
   logic [CW:0]   credit_used;
   logic          buf_empty, buf_full, tag_empty, tag_full;
   logic [31:0]   tag_pc;
   logic [31:0]   redirect_pc_aligned;
   logic          accept, resp, live, take, d_xfer;
   pd_kind_t      pd_kind;
   logic          pred_taken;
   logic [31:0]   pred_target;
   fetch_entry_t  push_entry, head_entry;
   logic [EW-1:0] head_bits;

   // Every outstanding request and every buffered word holds one credit,
   // so a returning response always finds room in the buffer.
   assign credit_used = {1'b0, inflight} + {1'b0, buf_count};
   assign imem_req    = ~rst & ~redirect & (credit_used < CREDITS)
                        & ~tag_full & ~buf_full;
   assign imem_addr   = pc_q;

   assign accept = imem_req & imem_gnt;
   // Responses with nothing outstanding are strays and are ignored.
   assign resp   = imem_rvalid & ~tag_empty;
   // A response is kept only if it is not a leftover from before a flush.
   assign live   = resp & (drop_q == '0) & ~redirect;

   assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

   // Static prediction on the returning word, relative to its request PC.
   always_comb begin
      pd_kind     = predecode(imem_rdata);
      pred_taken  = (pd_kind != PD_SEQ);
      pred_target = tag_pc + ((pd_kind == PD_JAL) ? imm_j(imem_rdata)
                                                   : imm_b(imem_rdata));
   end

   assign take = live & pred_taken;

   assign push_entry = '{pc: tag_pc, ir: imem_rdata, predicted_taken: pred_taken};

   // The tag queue occupancy is the in-flight count; this is its value once
   // this cycle's accept and response have been applied.
   assign inflight_next = inflight + CW'(accept) - CW'(resp);

   // PC priority: external redirect, then predicted target, then PC+4.
   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = redirect_pc_aligned;
      end else if (take) begin
         pc_d = pred_target;
      end else if (accept) begin
         pc_d = pc_q + 32'd4;
      end
   end

   // Any flush makes every request still outstanding afterwards stale.
   always_comb begin
      drop_d = drop_q;
      if (redirect || take) begin
         drop_d = inflight_next;
      end else if (resp && drop_q != '0) begin
         drop_d = drop_q - CW'(1);
      end
   end

   // PC and drop-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   // Request PCs, popped in order as responses return (dropped or not).
   core_fetch_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_tag_q (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .wdata (pc_q),
      .pop   (resp),
      .clear (1'b0),
      .rdata (tag_pc),
      .count (inflight),
      .empty (tag_empty),
      .full  (tag_full)
   );

   assign d_xfer = d_valid & d_ready;

   // Instructions waiting for decode; a redirect empties it.
   core_fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fetch_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (live),
      .wdata (push_entry),
      .pop   (d_xfer),
      .clear (redirect),
      .rdata (head_bits),
      .count (buf_count),
      .empty (buf_empty),
      .full  (buf_full)
   );

   // Present the head entry; outputs read as zero while nothing is buffered.
   always_comb begin
      head_entry        = fetch_entry_t'(head_bits);
      d_valid           = ~buf_empty;
      d_pc              = '0;
      d_ir              = '0;
      d_predicted_taken = 1'b0;
      if (!buf_empty) begin
         d_pc              = head_entry.pc;
         d_ir              = head_entry.ir;
         d_predicted_taken = head_entry.predicted_taken;
      end
   end

endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: an in-order memory model with programmable delays and
// a reference that tracks the architectural PC stream delivered to decode.
module tb_core_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        d_valid;
   logic        d_ready;
   logic [31:0] d_pc;
   logic [31:0] d_ir;
   logic        d_predicted_taken;

   core_fetch #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_gnt          (imem_gnt),
      .imem_rvalid       (imem_rvalid),
      .imem_rdata        (imem_rdata),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .d_valid           (d_valid),
      .d_ready           (d_ready),
      .d_pc              (d_pc),
      .d_ir              (d_ir),
      .d_predicted_taken (d_predicted_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } req_t;

   req_t        rq[$];
   logic [31:0] acc_log[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          mem_mode = 0;
   int          gnt_pct = 100, rsp_pct = 100, rdy_pct = 100;
   int          dly_min = 0, dly_max = 0;
   bit          stray_en = 0;
   bit          rst_next = 1, rst_seen = 0;
   bit          redir_req = 0, redir_on_taken = 0;
   logic [31:0] redir_addr = '0;
   int          taken_redir_hits = 0;
   logic [31:0] exp_pc = RESET_PC;
   bit          chk_dv0 = 0, chk_addr = 0;
   logic [31:0] chk_addr_val = '0;
   int          n_xfer = 0, n_pt = 0;
   int          rel_cyc = 0, first_dv = -1;
   logic        s_req, s_dv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
      logic [12:0] i;
      i = imm[12:0];
      return {i[12], i[10:5], 5'd1, 5'd2, f3, i[4:1], i[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input int imm);
      logic [20:0] i;
      i = imm[20:0];
      return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
   endfunction

   // Program image: word at an address, whether it should be predicted
   // taken, and the architectural PC step to the next delivered instruction.
   function automatic void info(input logic [31:0] a, output logic [31:0] w,
                                output bit tk, output int off);
      logic [31:0] h;
      w   = 32'h0000_0013;
      tk  = 0;
      off = 4;
      if (mem_mode == 1 && a == 32'h10) begin
         w   = 32'hFE00_0EE3;
         tk  = 1;
         off = -4;
      end else if (mem_mode == 2) begin
         h = {2'b00, a[31:2]} * 32'h9E37_79B1;
         case (h[31:29])
            3'd0: begin off = -4 * (int'(h[3:0]) + 1); w = enc_b(off, 3'b000); tk = 1; end
            3'd1: begin off = 4 * (int'(h[7:4]) + 1); w = enc_j(off); tk = 1; end
            3'd2: w = enc_b(4 * (int'(h[3:0]) + 2), 3'b101);
            3'd3: w = {12'h000, 5'd1, 3'b000, 5'd1, 7'b1100111};
            3'd4: begin off = -64 * (int'(h[11:8]) + 1); w = enc_j(off); tk = 1; end
            default: w = {h[27:3], 7'b0110011};
         endcase
      end
   endfunction

   // One clock: drive inputs at the falling edge, sample outputs just after,
   // then advance the memory and reference models at the rising edge.
   task automatic cycle();
      logic [31:0] w, acc_addr;
      bit          tk, rv_now, acc, xfer;
      int          off;
      @(negedge clk);
      rst      = rst_next;
      tk       = 0;
      rv_now   = 0;
      imem_gnt = ($urandom_range(99) < gnt_pct);
      imem_rdata = $urandom();
      if (!rst && rq.size() > 0 && rq[0].ready <= cyc)
         rv_now = ($urandom_range(99) < rsp_pct);
      if (rv_now) begin
         info(rq[0].addr, w, tk, off);
         imem_rdata = w;
      end else if (stray_en && !rst && rq.size() == 0 && $urandom_range(3) == 0) begin
         rv_now = 1;
      end
      imem_rvalid = rv_now;
      d_ready     = ($urandom_range(99) < rdy_pct);
      redirect    = 0;
      if (!rst && redir_req) begin
         redirect    = 1;
         redirect_pc = redir_addr;
         redir_req   = 0;
      end else if (!rst && redir_on_taken && rv_now && tk) begin
         redirect       = 1;
         redirect_pc    = redir_addr;
         redir_on_taken = 0;
         taken_redir_hits++;
      end
      #1;
      s_req = imem_req;
      s_dv  = d_valid;
      if (rst) begin
         check("req_in_reset", imem_req, 0);
         if (rst_seen) begin
            check("rst_d_valid", d_valid, 0);
            check("rst_d_pc", d_pc, 0);
            check("rst_d_ir", d_ir, 0);
            check("rst_d_pt", d_predicted_taken, 0);
         end
      end else begin
         if (d_valid && first_dv < 0) first_dv = rel_cyc;
         rel_cyc++;
         if (imem_req) begin
            check("addr_align", imem_addr[1:0], 0);
            check("credit", rq.size() < DEPTH, 1);
         end
         if (chk_dv0) begin
            check("dv_after_redirect", d_valid, 0);
            chk_dv0 = 0;
         end
         if (chk_addr && imem_req) begin
            check("addr_after_redirect", imem_addr, chk_addr_val);
            chk_addr = 0;
         end
         xfer = d_valid & d_ready;
         if (xfer) begin
            info(exp_pc, w, tk, off);
            check("d_pc", d_pc, exp_pc);
            check("d_ir", d_ir, w);
            check("d_pt", d_predicted_taken, tk);
            $display("xfer pc=%h ir=%h pt=%0d", d_pc, d_ir, d_predicted_taken);
            if (tk) n_pt++;
            exp_pc = exp_pc + 32'(off);
            n_xfer++;
         end
         if (redirect) begin
            exp_pc       = {redirect_pc[31:2], 2'b00};
            chk_dv0      = 1;
            chk_addr     = 1;
            chk_addr_val = exp_pc;
         end
      end
      acc      = imem_req & imem_gnt;
      acc_addr = imem_addr;
      @(posedge clk);
      cyc++;
      if (rst) begin
         rq.delete();
         acc_log.delete();
         exp_pc   = RESET_PC;
         chk_dv0  = 0;
         chk_addr = 0;
         rst_seen = 1;
         rel_cyc  = 0;
         first_dv = -1;
      end else begin
         rst_seen = 0;
         if (imem_rvalid && rq.size() > 0) void'(rq.pop_front());
         if (acc) begin
            rq.push_back('{addr: acc_addr, ready: cyc + dly_min + $urandom_range(dly_max - dly_min)});
            acc_log.push_back(acc_addr);
         end
      end
   endtask

   task automatic redirect_to(input logic [31:0] a, input int mode);
      redir_addr = a;
      redir_req  = 1;
      cycle();
      mem_mode = mode;
   endtask

   initial begin
      int base;
      rst = 1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
      redirect = 0; redirect_pc = '0; d_ready = 0;

      // Reset values
      repeat (3) cycle();

      // Straight-line NOPs, single-cycle memory, decode always ready
      rst_next = 0;
      repeat (16) cycle();
      check("first_dv_cycle", 32'(first_dv), 2);
      check("acc0", acc_log[0], 32'h0);
      check("acc1", acc_log[1], 32'h4);
      check("acc2", acc_log[2], 32'h8);
      check("t1_progress", n_xfer >= 6, 1);

      // Decode stalls for 5 cycles: buffer fills and requests stop
      rdy_pct = 0;
      repeat (5) cycle();
      check("stall_req_low", s_req, 0);
      check("stall_dv_high", s_dv, 1);
      base = n_xfer;
      rdy_pct = 100;
      repeat (10) cycle();
      check("stall_resume", n_xfer - base >= 4, 1);

      // Backward branch at 0x10 predicted taken, looping to 0x0C
      redirect_to(32'h0, 1);
      repeat (30) cycle();
      check("t3_taken_seen", n_pt >= 2, 1);

      // Redirect to 0x103 with two requests outstanding
      dly_min = 3; dly_max = 3;
      for (int i = 0; i < 30 && rq.size() != 2; i++) cycle();
      check("two_inflight", rq.size(), 2);
      redirect_to(32'h103, 1);
      repeat (15) cycle();
      check("t4_addr_checked", chk_addr, 0);

      // Redirect coinciding with a predicted-taken response
      dly_min = 0; dly_max = 0;
      redirect_to(32'h0, 1);
      redir_addr     = 32'h200;
      redir_on_taken = 1;
      for (int i = 0; i < 40 && redir_on_taken; i++) cycle();
      check("t5_hit", taken_redir_hits, 1);
      repeat (10) cycle();
      check("t5_addr_checked", chk_addr, 0);

      // Random program, delays, stalls, strays, redirects and a mid-run reset
      redirect_to(32'h0, 2);
      gnt_pct = 70; rsp_pct = 80; dly_min = 0; dly_max = 4; rdy_pct = 60; stray_en = 1;
      base = n_xfer;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) rst_next = 1;
         if (i == 1502) rst_next = 0;
         if (!rst_next && $urandom_range(99) == 0) begin
            redir_addr = 32'($urandom_range(4095));
            redir_req  = 1;
         end
         cycle();
      end
      check("t6_progress", n_xfer - base > 300, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
